hazard_stall_ctrl: RTL and testbench

- Central pipeline control unit for the 5-stage MIPS core.
- Detects load-use hazards, multi-cycle unit (MULT/DIV) busy conflicts, data-memory miss freezes and taken-branch redirects.
- Drives the hold/flush controls of the PC register, IF/ID register and ID/EX register.
- Keeps a busy countdown for the multi-cycle unit and a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hold/flush control for the 5-stage core: load-use, multi-cycle unit
// conflicts, data-memory freezes and taken-branch redirects.
module hazard_stall_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             id_mc_op,
    input  logic             id_mc_use,
    input  logic             id_branch_taken,
    input  logic             dmem_miss,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_bubble,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state_dbg
);
    localparam int MC_W = $clog2(MC_LAT + 1);
    localparam logic [MC_W-1:0]  MC_LOAD = MC_W'(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t          state;
    logic [MC_W-1:0] mc_cnt;
    logic            load_use;
    logic            mc_conflict;
    logic            hazard;
    logic            issue;

    assign load_use    = ex_memread && (ex_rt != 5'd0) &&
                         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mc_conflict = id_mc_use && (mc_cnt != '0);
    assign hazard      = load_use || mc_conflict;
    // A MULT/DIV only leaves ID when nothing is holding the front end this cycle.
    assign issue       = (state == RUN) && id_mc_op && (mc_cnt == '0) && !dmem_miss && !hazard;
    assign state_dbg   = state;

    // Memory handshake: dmem_miss opens a freeze in RUN; the freeze lasts until the
    // cycle dmem_ready is seen, which is the completion strobe for the stalled access.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_hold   = 1'b0;
        idex_bubble = 1'b0;
        mc_busy     = (mc_cnt != '0);
        if (rst) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            mc_busy     = 1'b0;
        end else begin
            case (state)
                INIT: begin
                    ifid_hold   = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                RUN: begin
                    if (dmem_miss) begin
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        idex_hold = 1'b1;
                    end else if (hazard) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (id_branch_taken) begin
                        ifid_hold  = 1'b1;
                        ifid_flush = 1'b1;
                    end
                end
                FREEZE: begin
                    if (!dmem_ready) begin
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        idex_hold = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            mc_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            case (state)
                INIT:    state <= RUN;
                RUN:     if (dmem_miss) state <= FREEZE;
                FREEZE:  if (dmem_ready) state <= RUN;
                default: state <= INIT;
            endcase
            if (issue) begin
                mc_cnt <= MC_LOAD;
            end else if (mc_cnt != '0) begin
                mc_cnt <= mc_cnt - MC_W'(1);
            end
            if (pc_hold && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a rule-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_hazard_stall_ctrl;
    localparam int MC_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rt, ex_memread, id_mc_op, id_mc_use, id_branch_taken, dmem_miss, dmem_ready;

    logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, mc_busy;
    logic [15:0] stall_cycles;
    logic [1:0] state_dbg;
    logic s_pc_hold, s_ifid_hold, s_ifid_flush, s_idex_hold, s_idex_bubble, s_mc_busy;
    logic [3:0] s_stall_cycles;
    logic [1:0] s_state_dbg;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MC_LAT(MC_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_mc_op(id_mc_op), .id_mc_use(id_mc_use),
        .id_branch_taken(id_branch_taken), .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_bubble(idex_bubble), .mc_busy(mc_busy),
        .stall_cycles(stall_cycles), .state_dbg(state_dbg)
    );

    hazard_stall_ctrl #(.MC_LAT(MC_LAT), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_mc_op(id_mc_op), .id_mc_use(id_mc_use),
        .id_branch_taken(id_branch_taken), .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
        .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .ifid_flush(s_ifid_flush),
        .idex_hold(s_idex_hold), .idex_bubble(s_idex_bubble), .mc_busy(s_mc_busy),
        .stall_cycles(s_stall_cycles), .state_dbg(s_state_dbg)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Model state: what the control unit should remember, in plain terms.
    bit m_fresh = 1'b1;     // first cycle after reset
    bit m_frozen = 1'b0;    // waiting on data memory
    int m_busy_left = 0;    // cycles until the multi-cycle unit is free
    int m_stalls = 0;       // true count of stalled cycles, unbounded

    // Expected vector order: {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble}
    always @(negedge clk) begin
        logic [4:0] srcs[$];
        bit lu, hz, busy_e;
        logic [4:0] e;
        srcs = {};
        srcs.push_back(id_rs);
        if (id_uses_rt) srcs.push_back(id_rt);
        lu = 1'b0;
        if (ex_memread && ex_rt != 5'd0)
            foreach (srcs[i]) if (srcs[i] == ex_rt) lu = 1'b1;
        hz = lu || (id_mc_use && m_busy_left > 0);
        busy_e = (m_busy_left > 0);
        if (rst) begin
            e = 5'b11101;
            busy_e = 1'b0;
        end else if (m_fresh) e = 5'b01101;
        else if (m_frozen) e = dmem_ready ? 5'b00000 : 5'b11010;
        else if (dmem_miss) e = 5'b11010;
        else if (hz) e = 5'b11001;
        else if (id_branch_taken) e = 5'b01100;
        else e = 5'b00000;

        check("model_ctl", {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble}, e);
        check("model_busy", mc_busy, busy_e);
        check("model_stalls", stall_cycles, (m_stalls > 65535) ? 65535 : m_stalls);
        check("model_ctl_s", {s_pc_hold, s_ifid_hold, s_ifid_flush, s_idex_hold, s_idex_bubble}, e);
        check("model_busy_s", s_mc_busy, busy_e);
        check("model_stalls_s", s_stall_cycles, (m_stalls > 15) ? 15 : m_stalls);

        if (rst) begin
            m_fresh = 1'b1;
            m_frozen = 1'b0;
            m_busy_left = 0;
            m_stalls = 0;
        end else begin
            if (e[4]) m_stalls++;
            if (!m_fresh && !m_frozen && id_mc_op && m_busy_left == 0 && !dmem_miss && !hz)
                m_busy_left = MC_LAT;
            else if (m_busy_left > 0)
                m_busy_left--;
            if (m_fresh) m_fresh = 1'b0;
            else if (m_frozen) m_frozen = !dmem_ready;
            else m_frozen = dmem_miss;
        end
    end

    task automatic clear();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0;
        id_mc_op = 1'b0; id_mc_use = 1'b0; id_branch_taken = 1'b0;
        dmem_miss = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_memread = 1'b1; ex_rt = rd; id_rs = rd;
    endtask

    initial begin
        rst = 1'b1;
        clear();
        // Reset
        settle();
        check("rst_pc_hold", pc_hold, 1);
        check("rst_ifid_flush", ifid_flush, 1);
        check("rst_idex_hold", idex_hold, 0);
        check("rst_stalls", stall_cycles, 0);
        next();
        settle();
        next();
        rst = 1'b0;
        // INIT purge cycle
        settle();
        check("init_pc_hold", pc_hold, 0);
        check("init_ifid_flush", ifid_flush, 1);
        check("init_idex_bubble", idex_bubble, 1);
        next();
        settle(); next();
        // Load-use on rs
        set_lu(5'd5);
        settle();
        check("lu_pc_hold", pc_hold, 1);
        check("lu_idex_bubble", idex_bubble, 1);
        check("lu_ifid_flush", ifid_flush, 0);
        next();
        clear();
        settle();
        check("lu_release_pc_hold", pc_hold, 0);
        check("lu_stalls", stall_cycles, 1);
        next();
        // Load to $0 never stalls
        set_lu(5'd0);
        settle();
        check("lu_r0_pc_hold", pc_hold, 0);
        next();
        // rt match only counts when rt is a source
        clear(); ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
        settle();
        check("rt_unused_pc_hold", pc_hold, 0);
        next();
        id_uses_rt = 1'b1;
        settle();
        check("rt_used_pc_hold", pc_hold, 1);
        next();
        // Branch redirect, then branch under a load-use
        clear(); id_branch_taken = 1'b1;
        settle();
        check("br_ifid_flush", ifid_flush, 1);
        check("br_pc_hold", pc_hold, 0);
        next();
        set_lu(5'd9);
        settle();
        check("br_lu_ifid_flush", ifid_flush, 0);
        check("br_lu_idex_bubble", idex_bubble, 1);
        next();
        clear(); id_branch_taken = 1'b1;
        settle();
        check("br_retry_ifid_flush", ifid_flush, 1);
        next();
        clear(); settle(); next();
        // MULT issue then MFHI waits out the latency
        id_mc_op = 1'b1; id_mc_use = 1'b1;
        settle();
        check("mult_issue_busy", mc_busy, 0);
        next();
        id_mc_op = 1'b0;
        for (int i = 0; i < MC_LAT; i++) begin
            settle();
            check("mfhi_wait_pc_hold", pc_hold, 1);
            next();
        end
        settle();
        check("mfhi_release_pc_hold", pc_hold, 0);
        check("mfhi_release_busy", mc_busy, 0);
        check("mfhi_stalls", stall_cycles, 7);
        next();
        // Back-to-back MULTs
        id_mc_op = 1'b1; id_mc_use = 1'b1;
        for (int i = 0; i < MC_LAT + 2; i++) begin settle(); next(); end
        clear();
        settle();
        check("mult2_issued_busy", mc_busy, 1);
        check("mult2_stalls", stall_cycles, 11);
        next();
        for (int i = 0; i < MC_LAT; i++) begin settle(); next(); end
        // Memory freeze with a branch arriving mid-freeze
        dmem_miss = 1'b1;
        settle();
        check("frz_idex_hold", idex_hold, 1);
        next();
        id_branch_taken = 1'b1;
        settle();
        check("frz_br_ifid_flush", ifid_flush, 0);
        check("frz_br_pc_hold", pc_hold, 1);
        next();
        clear();
        settle(); next();
        dmem_ready = 1'b1;
        settle();
        check("frz_done_pc_hold", pc_hold, 0);
        check("frz_done_idex_hold", idex_hold, 0);
        next();
        clear();
        settle();
        check("frz_stalls", stall_cycles, 14);
        next();
        // Reset during a freeze while the multi-cycle unit is counting
        id_mc_op = 1'b1;
        settle(); next();
        clear(); dmem_miss = 1'b1;
        settle(); next();
        clear();
        settle(); next();
        rst = 1'b1;
        settle();
        check("rst_mid_busy", mc_busy, 0);
        check("rst_mid_idex_hold", idex_hold, 0);
        check("rst_mid_ifid_flush", ifid_flush, 1);
        check("rst_mid_stalls", stall_cycles, 16);
        check("rst_mid_stalls_sat", s_stall_cycles, 15);
        next();
        rst = 1'b0;
        settle();
        check("post_rst_init_flush", ifid_flush, 1);
        check("post_rst_stalls", stall_cycles, 0);
        next();
        settle();
        check("post_rst_run_busy", mc_busy, 0);
        check("post_rst_run_pc_hold", pc_hold, 0);
        next();
        // Saturation of the narrow counter
        set_lu(5'd12);
        for (int i = 0; i < 20; i++) begin settle(); next(); end
        clear();
        settle();
        check("sat_stalls_narrow", s_stall_cycles, 15);
        check("sat_stalls_wide", stall_cycles, 20);
        next();
        settle(); next();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
